// File: rtl/mbl_pkt_framer.sv
// Packet framer for the mbl link: slices a raw word stream into packets of
// pkt_len body words, optionally led by a {seq, len} header word.
module mbl_pkt_framer #(
    parameter int HDR_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_pkt_len,
    input  logic [31:0] i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [31:0] o_data,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy
);

    localparam bit HAS_HDR = (HDR_EN != 0);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } state_t;

    state_t      r_state;
    logic [8:0]  r_len;
    logic [8:0]  r_cnt;
    logic [15:0] r_seq;
    logic [31:0] r_data;
    logic        r_sof;
    logic        r_eof;
    logic        r_valid;

    logic w_load_ok;
    logic w_accept;
    logic w_first;
    logic w_last;

    // The output register may take a new word when empty or being drained this cycle.
    assign w_load_ok = !r_valid || i_ready;
    assign w_accept  = i_in_valid && o_in_ready;
    assign w_first   = (r_cnt == 9'd0);
    assign w_last    = (r_cnt == (r_len - 9'd1));

    assign o_in_ready = (r_state == BODY) && w_load_ok;
    assign o_busy     = (r_state != IDLE);
    assign o_data     = r_data;
    assign o_sof      = r_sof;
    assign o_eof      = r_eof;
    assign o_valid    = r_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_len   <= 9'd0;
            r_cnt   <= 9'd0;
            r_seq   <= 16'd0;
            r_data  <= 32'd0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            // A completed transfer empties the register unless a load below refills it.
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_len   <= (i_pkt_len == 8'd0) ? 9'd256 : {1'b0, i_pkt_len};
                        r_cnt   <= 9'd0;
                        r_state <= HAS_HDR ? HDR : BODY;
                    end
                end

                HDR: begin
                    if (w_load_ok) begin
                        r_data  <= {r_seq, 7'd0, r_len};
                        r_sof   <= 1'b1;
                        r_eof   <= 1'b0;
                        r_valid <= 1'b1;
                        r_seq   <= r_seq + 16'd1;
                        r_state <= BODY;
                    end
                end

                BODY: begin
                    if (w_accept) begin
                        r_data  <= i_in_data;
                        r_sof   <= !HAS_HDR && w_first;
                        r_eof   <= w_last;
                        r_valid <= 1'b1;
                        r_cnt   <= r_cnt + 9'd1;
                        // Without a header the sequence number still advances once per packet.
                        if (!HAS_HDR && w_first) begin
                            r_seq <= r_seq + 16'd1;
                        end
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbl_pkt_framer.sv
// Scoreboard bench for mbl_pkt_framer: instance 0 with header, instance 1 without,
// each output transfer popped from a per-instance queue of expected words.
module tb_mbl_pkt_framer;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  pktLen   [2];
    logic [31:0] inData   [2];
    logic        inValid  [2];
    logic        inReady  [2];
    logic [31:0] outData  [2];
    logic        outSof   [2];
    logic        outEof   [2];
    logic        outValid [2];
    logic        readyIn  [2];
    logic        outBusy  [2];

    exp_t        expQ0[$];
    exp_t        expQ1[$];
    logic [15:0] seqModel [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mbl_pkt_framer #(.HDR_EN(1)) dut0 (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_pkt_len  (pktLen[0]),
        .i_in_data  (inData[0]),
        .i_in_valid (inValid[0]),
        .o_in_ready (inReady[0]),
        .o_data     (outData[0]),
        .o_sof      (outSof[0]),
        .o_eof      (outEof[0]),
        .o_valid    (outValid[0]),
        .i_ready    (readyIn[0]),
        .o_busy     (outBusy[0])
    );

    mbl_pkt_framer #(.HDR_EN(0)) dut1 (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_pkt_len  (pktLen[1]),
        .i_in_data  (inData[1]),
        .i_in_valid (inValid[1]),
        .o_in_ready (inReady[1]),
        .o_data     (outData[1]),
        .o_sof      (outSof[1]),
        .o_eof      (outEof[1]),
        .o_valid    (outValid[1]),
        .i_ready    (readyIn[1]),
        .o_busy     (outBusy[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input int i, input logic [31:0] d, input logic s, input logic e);
        exp_t x;
        x.data = d;
        x.sof  = s;
        x.eof  = e;
        if (i == 0) expQ0.push_back(x);
        else        expQ1.push_back(x);
    endtask

    task automatic checkResetState(input int i);
        checkOutput($sformatf("rst_valid%0d", i),   64'(outValid[i]), 64'd0);
        checkOutput($sformatf("rst_busy%0d", i),    64'(outBusy[i]),  64'd0);
        checkOutput($sformatf("rst_inready%0d", i), 64'(inReady[i]),  64'd0);
        checkOutput($sformatf("rst_sof%0d", i),     64'(outSof[i]),   64'd0);
        checkOutput($sformatf("rst_eof%0d", i),     64'(outEof[i]),   64'd0);
        checkOutput($sformatf("rst_data%0d", i),    64'(outData[i]),  64'd0);
    endtask

    // Pops one expected word per output transfer and watches that stalled words hold.
    task automatic monitor();
        logic        prevStall [2];
        logic [31:0] prevData  [2];
        exp_t        e;
        bit          have;
        prevStall[0] = 1'b0;
        prevStall[1] = 1'b0;
        prevData[0]  = 32'd0;
        prevData[1]  = 32'd0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rstN) begin
                    prevStall[i] = 1'b0;
                end else begin
                    if (prevStall[i]) begin
                        checkOutput($sformatf("hold_valid%0d", i), 64'(outValid[i]), 64'd1);
                        checkOutput($sformatf("hold_data%0d", i),  64'(outData[i]),  64'(prevData[i]));
                    end
                    if (outValid[i] && readyIn[i]) begin
                        have = 1'b0;
                        if (i == 0 && expQ0.size() != 0) begin
                            e = expQ0.pop_front();
                            have = 1'b1;
                        end else if (i == 1 && expQ1.size() != 0) begin
                            e = expQ1.pop_front();
                            have = 1'b1;
                        end
                        if (have) begin
                            checkOutput($sformatf("xfer%0d", i),
                                        64'({outData[i], outSof[i], outEof[i]}),
                                        64'({e.data, e.sof, e.eof}));
                        end else begin
                            checkOutput($sformatf("unexpected_xfer%0d", i), 64'(outData[i]), 64'hDEAD_0000_0000);
                        end
                    end
                    prevStall[i] = outValid[i] && !readyIn[i];
                    prevData[i]  = outData[i];
                end
            end
        end
    endtask

    task automatic waitAccept(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inReady[i] && n < 64);
        if (!inReady[i]) checkOutput($sformatf("accept_timeout%0d", i), 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        int k = 0;
        while ((expQ0.size() + expQ1.size()) != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("drain", 64'(expQ0.size() + expQ1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Queues the whole expected packet, then feeds its words; optionally stalls after word stallIdx.
    task automatic applyStimulus(input int i, input logic [7:0] lenCode, input logic [31:0] base,
                                 input int stallIdx, input bit gapCheck);
        int len;
        int n;
        len = (lenCode == 8'd0) ? 256 : int'(lenCode);
        pktLen[i] = lenCode;
        if (i == 0) pushExp(0, {seqModel[0], 16'(len)}, 1'b1, 1'b0);
        for (int w = 0; w < len; w++) begin
            pushExp(i, base + 32'(w), (i == 1) && (w == 0), w == len - 1);
        end
        seqModel[i] = seqModel[i] + 16'd1;
        for (int w = 0; w < len; w++) begin
            inData[i]  = base + 32'(w);
            inValid[i] = 1'b1;
            waitAccept(i, n);
            if (gapCheck && w > 0) checkOutput($sformatf("gap%0d_w%0d", i, w), 64'(n), 64'd1);
            @(posedge clk);
            #1;
            if (w == 0) pktLen[i] = lenCode + 8'd5;
            if (w == stallIdx) begin
                readyIn[i] = 1'b0;
                inData[i]  = base + 32'(w + 1);
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_valid",   64'(outValid[i]), 64'd1);
                    checkOutput("stall_data",    64'(outData[i]),  64'(base + 32'(w)));
                    checkOutput("stall_inready", 64'(inReady[i]),  64'd0);
                end
                @(posedge clk);
                #1;
                readyIn[i] = 1'b1;
            end
        end
        inValid[i] = 1'b0;
    endtask

    initial begin
        int n;
        rstN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pktLen[i]   = 8'd0;
            inData[i]   = 32'd0;
            inValid[i]  = 1'b0;
            readyIn[i]  = 1'b1;
            seqModel[i] = 16'd0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkResetState(0);
        checkResetState(1);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 8'd3, 32'hA000_0000, -1, 1'b1);
        applyStimulus(0, 8'd3, 32'hA100_0000, -1, 1'b1);
        applyStimulus(0, 8'd3, 32'hB000_0000, 1, 1'b0);
        applyStimulus(0, 8'd0, 32'hC000_0000, -1, 1'b1);
        applyStimulus(1, 8'd1, 32'hD000_0000, -1, 1'b1);
        applyStimulus(1, 8'd1, 32'hD100_0000, -1, 1'b1);
        applyStimulus(1, 8'd3, 32'hD200_0000, -1, 1'b1);
        waitDrain();

        // Abandon a 4-word packet right after its second body word is loaded.
        pktLen[0] = 8'd4;
        pushExp(0, {seqModel[0], 16'd4}, 1'b1, 1'b0);
        pushExp(0, 32'hE000_0000, 1'b0, 1'b0);
        inData[0]  = 32'hE000_0000;
        inValid[0] = 1'b1;
        waitAccept(0, n);
        @(posedge clk);
        #1;
        inData[0] = 32'hE000_0001;
        waitAccept(0, n);
        @(posedge clk);
        #1;
        rstN       = 1'b0;
        inValid[0] = 1'b0;
        @(posedge clk);
        #1;
        checkResetState(0);
        checkResetState(1);
        checkOutput("queue_at_reset", 64'(expQ0.size()), 64'd0);
        expQ0.delete();
        seqModel[0] = 16'd0;
        seqModel[1] = 16'd0;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 8'd4, 32'hE100_0000, -1, 1'b1);
        applyStimulus(1, 8'd1, 32'hF000_0000, -1, 1'b1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbl_pkt_framer.md
MBL_PKT_FRAMER -- requirements
Module: mbl_pkt_framer

Interface
REQ-001 Parameter HDR_EN, default 1: 1 = prepend one header word to every packet; 0 = no header.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pkt_len  input  8  body words per packet; 0 encodes 256; sampled only at packet start.
REQ-005 in_data  input  32  raw word stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  word accepted when in_valid & in_ready.
REQ-008 data  output  32  framed word, drives master side of the mbl link.
REQ-009 sof  output  1  first word of packet.
REQ-010 eof  output  1  last word of packet.
REQ-011 valid  output  1  data/sof/eof valid.
REQ-012 ready  input  1  downstream slave accepts when valid & ready.
REQ-013 busy  output  1  high while in HDR or BODY state.

Function
REQ-014 Output register: data/sof/eof/valid registered; a load is allowed when (!valid | ready); "xfer" = valid & ready.
REQ-015 While valid=1 & ready=0, data/sof/eof/valid held stable; valid never drops without a transfer.
REQ-016 FSM states IDLE, HDR, BODY; reset state IDLE.
REQ-017 IDLE: in_ready=0; when in_valid=1, latch len = (pkt_len==0 ? 256 : pkt_len) and cnt=0, then go to HDR if HDR_EN=1, else to BODY; the input word is not consumed in IDLE.
REQ-018 HDR: on load, drive data = {seq[15:0], len[15:0]}, sof=1, eof=0, valid=1; increment seq (16-bit, FFFF wraps to 0000); go to BODY.
REQ-019 BODY: in_ready = (!valid | ready); on input accept, load data=in_data, valid=1 and increment cnt.
REQ-019a BODY sof = (HDR_EN==0 & cnt==0).
REQ-019b BODY eof = (cnt==len-1).
REQ-020 On accepting the eof word, go to IDLE; valid stays set until that word transfers.
REQ-021 HDR_EN=0: seq still increments once per packet, on the sof word load.
REQ-021a HDR_EN=0 with len=1: the single word carries sof=1 and eof=1.
REQ-022 If no new load coincides with an xfer, clear valid.
REQ-023 Throughput: one word per cycle sustained in BODY while ready=1; in_data to data latency is 1 cycle.
REQ-024 Per-packet overhead: 1 cycle in IDLE, plus 1 cycle in HDR when HDR_EN=1.
REQ-025 cnt is 9 bits and supports len=256 exactly; the packet ends at cnt=255 with no early wrap.
REQ-026 pkt_len changes mid-packet have no effect until the next IDLE sample.
REQ-027 busy = (state != IDLE).

Reset
REQ-028 When rst_n=0 at a clock edge, the next cycle shows:
- state=IDLE;
- valid=0, sof=0, eof=0, data=0;
- in_ready=0, busy=0;
- seq=0, cnt=0, len=0.
REQ-029 Reset mid-packet abandons the partial packet: no eof is issued and the held output word is discarded.
REQ-030 The first packet after reset uses seq=0.

Verification
REQ-031 HDR_EN=1, pkt_len=3, in words A,B,C, ready=1 -> data: {0000,0003} (sof), A, B, C (eof); next packet header {0001,0003}.
REQ-032 HDR_EN=1, pkt_len=0, 256 words with ready=1 -> header len field 0x0100; eof on the 256th body word only; no gaps inside the body.
REQ-033 ready=0 for 5 cycles while the body word B is held -> data=B and valid=1 stable for all 5 cycles; in_ready=0 throughout; no input word lost or duplicated.
REQ-034 HDR_EN=0, pkt_len=1, words X,Y -> two packets, each a single word with sof=1 and eof=1; no header words.
REQ-035 rst_n=0 for 1 cycle after the 2nd body word of a 4-word packet -> the next cycle shows valid=0 and busy=0; the next packet header has seq 0000 and is well-formed.
REQ-036 seq preset to FFFF by sending 65535 packets -> that packet's header carries FFFF; the following header carries 0000.
